// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and constants for the program-counter generator
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } state_t;

    typedef enum logic [1:0] {
        SRC_SEQ,
        SRC_BR,
        SRC_JALR,
        SRC_TRAP
    } src_t;

    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/pc_target_calc.sv
// rtl/pc_target_calc.sv - combinational next-PC target and alignment check
module pc_target_calc
    import pc_pkg::*;
#(
    parameter int                ADDR_W   = 10,
    parameter int                OFFS_W   = 20,
    parameter logic [ADDR_W-1:0] TRAP_VEC = ADDR_W'('h100)
) (
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [OFFS_W-1:0] i_jump_offset,
    input  logic [ADDR_W-1:0] i_jalr_target,
    input  src_t              i_src,
    output logic [ADDR_W-1:0] o_target,
    output logic              o_target_misaligned
);

    // Add at the wider of the two widths so the offset is sign-extended or
    // truncated correctly, then keep the low ADDR_W bits (modulo wrap).
    localparam int SUM_W = (ADDR_W > OFFS_W) ? ADDR_W : OFFS_W;

    logic [SUM_W-1:0]  w_pc_ext;
    logic [SUM_W-1:0]  w_off_ext;
    logic [SUM_W-1:0]  w_br_sum;
    logic              w_unused_sum;
    logic [ADDR_W-1:0] w_target;

    assign w_pc_ext     = SUM_W'(i_pc);
    assign w_off_ext    = SUM_W'($signed(i_jump_offset));
    assign w_br_sum     = w_pc_ext + w_off_ext;
    assign w_unused_sum = ^w_br_sum;

    always_comb begin
        w_target = i_pc;
        case (i_src)
            SRC_SEQ:  w_target = i_pc + ADDR_W'(INSTR_BYTES);
            SRC_BR:   w_target = w_br_sum[ADDR_W-1:0] & ~ADDR_W'(1);
            SRC_JALR: w_target = i_jalr_target & ~ADDR_W'(1);
            SRC_TRAP: w_target = TRAP_VEC;
            default:  w_target = i_pc;
        endcase
    end

    assign o_target            = w_target;
    assign o_target_misaligned = ((i_src == SRC_BR) || (i_src == SRC_JALR)) && w_target[1];

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch PC register, next-PC selection and BOOT/RUN/HALT control
module pc_gen
    import pc_pkg::*;
#(
    parameter int                ADDR_W    = 10,
    parameter int                OFFS_W    = 20,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'('h100)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch,
    input  logic [OFFS_W-1:0] jump_offset,
    input  logic              jalr,
    input  logic [ADDR_W-1:0] jalr_target,
    input  logic              trap,
    input  logic              fetch_ready,
    output logic              fetch_valid,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              misaligned
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_fetch_valid;
    logic              r_misaligned;

    src_t              w_src;
    logic [ADDR_W-1:0] w_target;
    logic              w_target_misaligned;

    always_comb begin
        w_src = SRC_SEQ;
        if (trap)
            w_src = SRC_TRAP;
        else if (jalr)
            w_src = SRC_JALR;
        else if (branch)
            w_src = SRC_BR;
    end

    pc_target_calc #(
        .ADDR_W   (ADDR_W),
        .OFFS_W   (OFFS_W),
        .TRAP_VEC (TRAP_VEC)
    ) u_target_calc (
        .i_pc                (r_pc),
        .i_jump_offset       (jump_offset),
        .i_jalr_target       (jalr_target),
        .i_src               (w_src),
        .o_target            (w_target),
        .o_target_misaligned (w_target_misaligned)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= BOOT;
            r_pc          <= RESET_VEC;
            r_fetch_valid <= 1'b0;
            r_misaligned  <= 1'b0;
        end else begin
            r_misaligned <= 1'b0;
            case (r_state)
                BOOT: begin
                    r_state       <= RUN;
                    r_fetch_valid <= 1'b1;
                end
                RUN: begin
                    // Redirects ignore stall/ready; any unaccepted fetch is dropped.
                    if (w_src == SRC_TRAP) begin
                        r_pc <= w_target;
                    end else if (w_src != SRC_SEQ) begin
                        if (w_target_misaligned) begin
                            r_state       <= HALT;
                            r_fetch_valid <= 1'b0;
                            r_misaligned  <= 1'b1;
                        end else begin
                            r_pc <= w_target;
                        end
                    end else if (r_fetch_valid && fetch_ready && !stall) begin
                        r_pc <= w_target;
                    end
                end
                HALT: begin
                    if (trap) begin
                        r_state       <= RUN;
                        r_pc          <= TRAP_VEC;
                        r_fetch_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= BOOT;
                    r_fetch_valid <= 1'b0;
                end
            endcase
        end
    end

    assign pc_out      = r_pc;
    assign pc_plus4    = r_pc + ADDR_W'(INSTR_BYTES);
    assign fetch_valid = r_fetch_valid;
    assign misaligned  = r_misaligned;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - table-driven scoreboard bench for pc_gen
module tb_pc_gen;

    localparam int ADDR_W = 10;
    localparam int OFFS_W = 20;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              stall = 1'b0;
    logic              branch = 1'b0;
    logic [OFFS_W-1:0] jump_offset = '0;
    logic              jalr = 1'b0;
    logic [ADDR_W-1:0] jalr_target = '0;
    logic              trap = 1'b0;
    logic              fetch_ready = 1'b0;
    logic              fetch_valid;
    logic [ADDR_W-1:0] pc_out;
    logic [ADDR_W-1:0] pc_plus4;
    logic              misaligned;

    pc_gen #(
        .ADDR_W    (ADDR_W),
        .OFFS_W    (OFFS_W),
        .RESET_VEC (10'h000),
        .TRAP_VEC  (10'h100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .branch      (branch),
        .jump_offset (jump_offset),
        .jalr        (jalr),
        .jalr_target (jalr_target),
        .trap        (trap),
        .fetch_ready (fetch_ready),
        .fetch_valid (fetch_valid),
        .pc_out      (pc_out),
        .pc_plus4    (pc_plus4),
        .misaligned  (misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              rst;
        logic              stl;
        logic              br;
        logic [OFFS_W-1:0] off;
        logic              jr;
        logic [ADDR_W-1:0] jt;
        logic              tr;
        logic              rdy;
        logic              fv;
        logic [ADDR_W-1:0] pc;
        logic              mis;
    } vec_t;

    typedef struct {
        logic              fv;
        logic [ADDR_W-1:0] pc;
        logic              mis;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic vec_t mk(int rst, int stl, int br, int off, int jr, int jt,
                                int tr, int rdy, int fv, int pc, int mis);
        vec_t v;
        v.rst = 1'(rst); v.stl = 1'(stl); v.br = 1'(br); v.off = OFFS_W'(off);
        v.jr = 1'(jr); v.jt = ADDR_W'(jt); v.tr = 1'(tr); v.rdy = 1'(rdy);
        v.fv = 1'(fv); v.pc = ADDR_W'(pc); v.mis = 1'(mis);
        return v;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        exp_t got;
        logic [ADDR_W-1:0] exp_p4;
        reset = v.rst; stall = v.stl; branch = v.br; jump_offset = v.off;
        jalr = v.jr; jalr_target = v.jt; trap = v.tr; fetch_ready = v.rdy;
        e.fv = v.fv; e.pc = v.pc; e.mis = v.mis;
        sb.push_back(e);
        @(posedge clk);
        #1;
        n_vec++;
        if (sb.size() == 0) begin
            n_miss++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            got = sb.pop_front();
            exp_p4 = got.pc + ADDR_W'(4);
            if (fetch_valid !== got.fv) begin
                n_miss++;
                $display("FAIL %s fetch_valid got %0b exp %0b", tag, fetch_valid, got.fv);
            end
            if (pc_out !== got.pc) begin
                n_miss++;
                $display("FAIL %s pc_out got 0x%03h exp 0x%03h", tag, pc_out, got.pc);
            end
            if (misaligned !== got.mis) begin
                n_miss++;
                $display("FAIL %s misaligned got %0b exp %0b", tag, misaligned, got.mis);
            end
            if (pc_plus4 !== exp_p4) begin
                n_miss++;
                $display("FAIL %s pc_plus4 got 0x%03h exp 0x%03h", tag, pc_plus4, exp_p4);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        //            rst stl br off     jr jt     tr rdy  fv pc     mis
        tbl.push_back(mk(1, 0, 0, 0,      0, 0,     0, 1,   0, 'h000, 0)); // reset
        tbl.push_back(mk(0, 0, 0, 0,      0, 0,     0, 1,   1, 'h000, 0)); // BOOT->RUN
        tbl.push_back(mk(0, 0, 0, 0,      0, 0,     0, 1,   1, 'h004, 0));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0,     0, 1,   1, 'h008, 0));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0,     0, 0,   1, 'h008, 0)); // not ready
        tbl.push_back(mk(0, 0, 0, 0,      0, 0,     0, 0,   1, 'h008, 0));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0,     0, 0,   1, 'h008, 0));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0,     0, 1,   1, 'h00C, 0));
        tbl.push_back(mk(0, 1, 0, 0,      0, 0,     0, 1,   1, 'h00C, 0)); // stall
        tbl.push_back(mk(0, 1, 0, 0,      0, 0,     0, 1,   1, 'h00C, 0));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0,     0, 1,   1, 'h010, 0));
        tbl.push_back(mk(0, 0, 1, 6,      0, 0,     0, 1,   0, 'h010, 1)); // misaligned
        tbl.push_back(mk(0, 0, 1, 0,      0, 0,     0, 1,   0, 'h010, 0)); // halted
        tbl.push_back(mk(0, 0, 0, 0,      1, 'h40,  0, 1,   0, 'h010, 0));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0,     1, 0,   1, 'h100, 0)); // trap out
        tbl.push_back(mk(0, 0, 1, -'hE0,  0, 0,     0, 1,   1, 'h020, 0));
        tbl.push_back(mk(0, 0, 1, -8,     0, 0,     0, 1,   1, 'h018, 0));
        tbl.push_back(mk(0, 0, 0, 0,      1, 'h41,  0, 1,   1, 'h040, 0));
        tbl.push_back(mk(0, 0, 1, 2,      1, 'h3,   1, 1,   1, 'h100, 0)); // trap wins
        tbl.push_back(mk(0, 0, 1, 2,      1, 'h80,  0, 1,   1, 'h080, 0)); // jalr wins
        tbl.push_back(mk(0, 0, 1, 0,      1, 'h86,  0, 1,   0, 'h080, 1)); // jalr checked
        tbl.push_back(mk(0, 0, 0, 0,      0, 0,     1, 1,   1, 'h100, 0));
        tbl.push_back(mk(0, 1, 1, 'h2FC,  0, 0,     0, 0,   1, 'h3FC, 0)); // redirect in stall
        tbl.push_back(mk(0, 0, 0, 0,      0, 0,     0, 1,   1, 'h000, 0)); // wrap
        tbl.push_back(mk(0, 0, 1, -4,     0, 0,     0, 1,   1, 'h3FC, 0)); // branch wrap
        tbl.push_back(mk(0, 0, 1, 5,      0, 0,     0, 1,   1, 'h000, 0)); // bit0 dropped
        tbl.push_back(mk(0, 0, 0, 0,      0, 0,     0, 1,   1, 'h004, 0));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0,     0, 0,   1, 'h004, 0));
        tbl.push_back(mk(1, 0, 0, 0,      0, 0,     0, 0,   0, 'h000, 0)); // reset, not ready
        tbl.push_back(mk(0, 0, 1, 'h40,   0, 0,     0, 1,   1, 'h000, 0)); // BOOT ignores br
        tbl.push_back(mk(0, 0, 1, 'h36,   0, 0,     0, 1,   0, 'h000, 1));
        tbl.push_back(mk(1, 0, 0, 0,      0, 0,     0, 1,   0, 'h000, 0)); // reset in HALT
        tbl.push_back(mk(0, 0, 0, 0,      0, 0,     0, 1,   1, 'h000, 0));

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("vec%0d", i));

        // Back-to-back throughput from 0
        for (int i = 0; i < 8; i++)
            apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 4 * (i + 1), 0), $sformatf("thru%0d", i));

        // Misaligned pulse lasts one cycle while HALT persists
        apply(mk(0, 0, 1, 2, 0, 0, 0, 1, 0, 'h020, 1), "mis_pulse");
        for (int i = 0; i < 3; i++)
            apply(mk(0, 1, 1, 4, 0, 0, 0, 1, 0, 'h020, 0), $sformatf("halt_hold%0d", i));
        apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 'h100, 0), "halt_trap");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 'h104, 0), "after_trap");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the RV32 core, replacing the fixed 10-bit PC. It holds the fetch address, presents it to instruction memory over a valid/ready handshake, and selects the next PC from sequential, PC-relative branch/JAL, register-indirect JALR, or trap-vector sources. It also detects misaligned control-flow targets and halts fetch until a trap redirect arrives.

## Interface
- ADDR_W, 10, PC / instruction-memory byte-address width (≥3)
- OFFS_W, 20, width of signed PC-relative offset
- RESET_VEC, 0, PC value loaded on reset (word aligned)
- TRAP_VEC, 'h100 truncated to ADDR_W, PC loaded on trap (word aligned)
- clk  in  1  clock; all state changes on posedge
- reset  in  1  synchronous, active-high
- stall  in  1  blocks sequential advance only
- branch  in  1  take PC-relative redirect: pc_out + sext(jump_offset)
- jump_offset  in  OFFS_W  signed byte offset, two's complement
- jalr  in  1  take absolute redirect to jalr_target with bit 0 cleared
- jalr_target  in  ADDR_W  absolute byte address (rs1+imm, computed upstream)
- trap  in  1  redirect to TRAP_VEC; highest priority
- fetch_ready  in  1  instruction memory accepts pc_out this cycle
- fetch_valid  out  1  pc_out is a valid fetch request
- pc_out  out  ADDR_W  current fetch address (registered)
- pc_plus4  out  ADDR_W  pc_out + 4 mod 2^ADDR_W (combinational, link value)
- misaligned  out  1  one-cycle pulse: rejected target had bit 1 set

## Operation
- States: BOOT, RUN, HALT.
- Reset: pc_out=RESET_VEC, state=BOOT, fetch_valid=0, misaligned=0. Reset overrides every other input.
- BOOT: fetch_valid=0 for exactly one cycle, then →RUN. Redirect inputs are ignored in BOOT.
- RUN: fetch_valid=1. Next-PC priority is trap > jalr > branch > sequential.
  - trap: pc_out←TRAP_VEC, stay RUN.
  - jalr: target = jalr_target & ~1.
  - branch: target = pc_out + sext(jump_offset), truncated to ADDR_W (modulo wrap).
  - For jalr/branch, if target[1]=1: pc_out unchanged, misaligned=1 next cycle, →HALT. Otherwise pc_out←target.
  - Redirects act on the next edge regardless of stall or fetch_ready. An unaccepted outstanding fetch is abandoned.
  - Sequential: pc_out←pc_out+4 only when fetch_valid & fetch_ready & ~stall. Otherwise hold.
- HALT: fetch_valid=0, pc_out held. branch, jalr, stall and fetch_ready are ignored. trap: pc_out←TRAP_VEC, →RUN.
- Wrap: pc_out = 2^ADDR_W−4 with sequential advance gives 0. Branch arithmetic wraps the same way. No overflow flag.
- Offsets are not required word aligned; only the resulting target's bit 1 is checked (bit 0 of a branch target is ignored/dropped as for jalr).

## Timing
- All outputs except pc_plus4 are registered. Redirect latency is 1 cycle: inputs sampled at edge N, new pc_out visible after edge N.
- misaligned is high for exactly the cycle after the offending edge, coincident with the first HALT cycle.
- Simultaneous trap+jalr+branch: trap wins and no misaligned check is made. jalr+branch: jalr wins and only the jalr target is checked.
- reset asserted mid-HALT or mid-stall: next cycle is BOOT at RESET_VEC, with misaligned cleared.
- Throughput: one PC per cycle when fetch_ready=1 and stall=0.

## Structure
- Package pc_pkg holds:
  - the state enum (BOOT, RUN, HALT);
  - the next-PC source enum (SRC_SEQ, SRC_BR, SRC_JALR, SRC_TRAP);
  - the INSTR_BYTES=4 constant.
- Sub-module pc_target_calc (combinational) takes pc_out, jump_offset, jalr_target and the source select. It returns the ADDR_W target and a target_misaligned flag. The top level holds the FSM and PC register.

## Test plan
- Reset with RESET_VEC=0, then fetch_ready=1: fetch_valid 0 for one cycle, then pc_out = 0, 4, 8, 12 on consecutive cycles.
- fetch_ready=0 for 3 cycles at pc_out=8: pc_out holds at 8 and fetch_valid stays 1. ready=1 → 12. Repeat the hold check with stall=1.
- At pc_out=0x20: branch with offset −8 → 0x18; jalr with target 0x41 → 0x40; trap+jalr together → TRAP_VEC.
- Branch with offset +6 at pc_out=0x10: misaligned pulses one cycle, pc_out holds 0x10, fetch_valid=0. Branch/jalr are ignored while halted. trap → TRAP_VEC with fetch_valid=1.
- ADDR_W=10 at pc_out=0x3FC with sequential advance → 0x000. Offset −4 at 0x000 → 0x3FC.
- reset asserted during HALT and during fetch_ready=0: next cycle pc_out=RESET_VEC, state BOOT, misaligned=0.
